fpu_issue_ctrl: RTL and testbench
=================================

Name: fpu_issue_ctrl

Overview:
Scheduler in front of the FPU (FADD/FMUL pair).
- Buffers FP ops from the decode stage in a small FIFO.
- Issues one op at a time using the FPU Start/Busy/Done handshake.
- Tracks each op's destination register itself.
- Holds the result until the register-file write port grants writeback.
- Provides a pending-destination scoreboard so decode can stall on RAW/WAW hazards.

Parameters:
DEPTH, 4, request FIFO entries (power of 2, >=2)
REG_AW, 4, register address width
TIMEOUT_CYCLES, 64, watchdog limit (used only with FPU_TIMEOUT_EN)

Ports:
CLK  in  1  clock
Reset  in  1  asynchronous, active-high reset
Req_Valid  in  1  decode offers an FP op
Req_Ready  out  1  op accepted when Req_Valid&Req_Ready at posedge
Req_Op  in  1  0=add, 1=mul
Req_Op1  in  32  operand 1
Req_Op2  in  32  operand 2
Req_WA3  in  REG_AW  destination register
Chk_RA1  in  REG_AW  hazard lookup address 1
Chk_RA2  in  REG_AW  hazard lookup address 2
Chk_Hazard  out  1  either lookup address has a pending FP write
FPU_Start  out  1  one-cycle issue pulse
FPU_Op  out  1  op of issuing entry
FPU_Operand1  out  32  operand 1 of FIFO head
FPU_Operand2  out  32  operand 2 of FIFO head
FPU_Busy  in  1  FPU busy
FPU_Done  in  1  FPU result valid (one-cycle pulse)
FPU_Result  in  32  FPU result
WB_Valid  out  1  result waiting for the write port
WB_WA3  out  REG_AW  writeback address
WB_Result  out  32  writeback data
WB_Ready  in  1  write port granted this cycle
Idle  out  1  FIFO empty and FSM in IDLE
Error  out  1  sticky watchdog flag (0 when feature is compiled out)

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - FIFO emptied, pending mask cleared, state IDLE.
  - FPU_Start=0, WB_Valid=0, WB_WA3=0, WB_Result=0, Error=0.
  - An in-flight FPU op is abandoned; the FPU is reset by the same Reset.
- Req_Ready = !full & !pending[Req_WA3].
  - Same-destination ops are serialized; no WAW stall inside the queue.
  - Acceptance at a posedge sets pending[Req_WA3] at that edge.
  - No bypass: a full FIFO does not accept in a cycle in which it pops.
- Chk_Hazard = pending[Chk_RA1] | pending[Chk_RA2]. Purely combinational.
- FIFO stores {op, op1, op2, wa3}. Pointers wrap modulo DEPTH. Push and pop in the same cycle leave the count unchanged.
- FSM states:
  - IDLE: if FIFO non-empty & !FPU_Busy -> ISSUE.
  - ISSUE: FPU_Start=1 for exactly this cycle. FPU_Op/Operand1/Operand2 are driven from the FIFO head. The head is popped at the end of the cycle and its wa3 latched into cur_wa3 -> WAIT.
  - WAIT: on FPU_Done, latch FPU_Result into WB_Result and cur_wa3 into WB_WA3 -> WB.
  - WB: WB_Valid=1. On WB_Ready, clear pending[WB_WA3], then:
    - FIFO non-empty & !FPU_Busy -> ISSUE
    - otherwise -> IDLE
- Latency: an op accepted at edge k with an empty queue gets FPU_Start high in the cycle after edge k+1. WB_Valid rises in the cycle after FPU_Done.
- FPU_Done outside WAIT is ignored.
- FPU_Operand*/FPU_Op are 0 outside ISSUE.
- Only one op is in flight; no new issue while a result is unretired.

Optional Feature:
FPU_TIMEOUT_EN
- Defined: a counter clears on ISSUE and increments in WAIT. On reaching TIMEOUT_CYCLES without FPU_Done:
  - Error is set (sticky until Reset).
  - pending[cur_wa3] is cleared.
  - FSM returns to IDLE; no writeback occurs.
- Undefined: no counter; Error tied 0; WAIT waits indefinitely.

Decomposition:
- Package fpu_ctrl_pkg:
  - state enum (IDLE, ISSUE, WAIT, WB)
  - FPU_OP_ADD=0, FPU_OP_MUL=1
  - REG_AW default
  - FIFO entry struct
- Sub-module: fpu_req_fifo (parameterized synchronous FIFO with full/empty/count).

Test Plan:
- Single add: op1=0x3F800000, op2=0x40000000, WA3=5; Done after 4 cycles, Result=0x40400000, WB_Ready=1 -> exactly one FPU_Start pulse; WB_Valid for 1 cycle with WB_WA3=5, WB_Result=0x40400000; Chk_Hazard(RA1=5) high until the writeback edge.
- Fill: 4 back-to-back mul ops (WA3=1..4), FPU_Busy held 1 -> Req_Ready=0 after the 4th; 5th request stalled; a pop re-opens Req_Ready next cycle; results retire in order 1,2,3,4.
- WAW stall: second request to WA3=7 while 7 is pending -> Req_Ready=0 until the writeback of 7, then accepted.
- Write-port backpressure: WB_Ready=0 for 10 cycles -> WB_Valid, WB_Result stable; no FPU_Start; retires on the first WB_Ready=1.
- Reset mid-WAIT: assert Reset during WAIT -> all outputs 0, Idle=1, Chk_Hazard=0 immediately; a late FPU_Done after reset is ignored.
- (FPU_TIMEOUT_EN) no Done for 64 cycles -> Error=1, pending bit cleared, FSM in IDLE, next queued op issues.

Source files
------------

// File: rtl/fpu_ctrl_pkg.sv
// fpu_ctrl_pkg
// Shared types and constants for the FPU issue controller.
//   state_t        : controller FSM states
//   FPU_OP_ADD/MUL : encoding of the single op-select bit
//   REG_AW_DEF     : default register address width
//   fpu_payload_t  : {op, op1, op2} part of a queued request; the destination
//                    address is appended by the controller because its width
//                    is a module parameter.
package fpu_ctrl_pkg;

    localparam int unsigned REG_AW_DEF = 4;

    localparam logic FPU_OP_ADD = 1'b0;
    localparam logic FPU_OP_MUL = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WB    = 2'd3
    } state_t;

    typedef struct packed {
        logic        op;
        logic [31:0] op1;
        logic [31:0] op2;
    } fpu_payload_t;

endpackage

// File: rtl/fpu_req_fifo.sv
// fpu_req_fifo
// Synchronous FIFO with occupancy count. Push while full and pop while empty
// are ignored; a simultaneous push and pop leaves the count unchanged.
// Ports:
//   CLK, Reset      : clock, asynchronous active-high reset (empties FIFO)
//   i_push, i_data  : write request and data
//   i_pop           : read request (o_data is the current head)
//   o_data          : head entry
//   o_full, o_empty : status flags
//   o_count         : number of stored entries (0..DEPTH)
module fpu_req_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     CLK,
    input  logic                     Reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_do_push) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl
// Scheduler in front of the FADD/FMUL pair: queues FP ops from decode, issues
// one at a time over the FPU Start/Busy/Done handshake, holds each result
// until the register-file write port grants it, and keeps a pending-write mask
// so decode can stall on RAW/WAW hazards.
// Handshakes: a request transfers at a posedge where Req_Valid & Req_Ready;
// a writeback retires at a posedge where WB_Valid & WB_Ready. WB_Valid,
// WB_WA3 and WB_Result stay stable until that retire edge.
// Optional build macro FPU_TIMEOUT_EN: watchdog on the WAIT state that
// abandons the op after TIMEOUT_CYCLES and sets the sticky Error flag.
// Ports:
//   CLK, Reset                     : clock, asynchronous active-high reset
//   Req_*                          : request channel from decode
//   Chk_RA1/RA2, Chk_Hazard        : combinational pending-write lookup
//   FPU_Start/Op/Operand1/Operand2 : issue side toward the FPU
//   FPU_Busy/Done/Result           : status and result from the FPU
//   WB_Valid/WA3/Result, WB_Ready  : writeback channel to the register file
//   Idle, Error                    : status
//   Dbg_State                      : current FSM state for observation
module fpu_issue_ctrl
    import fpu_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned REG_AW         = REG_AW_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Req_Valid,
    output logic              Req_Ready,
    input  logic              Req_Op,
    input  logic [31:0]       Req_Op1,
    input  logic [31:0]       Req_Op2,
    input  logic [REG_AW-1:0] Req_WA3,
    input  logic [REG_AW-1:0] Chk_RA1,
    input  logic [REG_AW-1:0] Chk_RA2,
    output logic              Chk_Hazard,
    output logic              FPU_Start,
    output logic              FPU_Op,
    output logic [31:0]       FPU_Operand1,
    output logic [31:0]       FPU_Operand2,
    input  logic              FPU_Busy,
    input  logic              FPU_Done,
    input  logic [31:0]       FPU_Result,
    output logic              WB_Valid,
    output logic [REG_AW-1:0] WB_WA3,
    output logic [31:0]       WB_Result,
    input  logic              WB_Ready,
    output logic              Idle,
    output logic              Error,
    output logic [1:0]        Dbg_State
);

    localparam int unsigned PAY_W = $bits(fpu_payload_t);
    localparam int unsigned ENT_W = PAY_W + REG_AW;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    state_t                 r_state;
    state_t                 w_next;
    logic [2**REG_AW-1:0]   r_pending;
    logic [REG_AW-1:0]      r_cur_wa3;
    logic [ENT_W-1:0]       w_fifo_wdata;
    logic [ENT_W-1:0]       w_fifo_rdata;
    logic                   w_full;
    logic                   w_empty;
    logic [CW-1:0]          w_count;
    fpu_payload_t           w_head;
    logic [REG_AW-1:0]      w_head_wa3;
    logic                   w_accept;
    logic                   w_pop;
    logic                   w_retire;
    logic                   w_timeout;

    // A destination already pending is refused here, so the queue never holds
    // two writes to the same register.
    assign Req_Ready    = ~w_full & ~r_pending[Req_WA3];
    assign w_accept     = Req_Valid & Req_Ready;
    assign Chk_Hazard   = r_pending[Chk_RA1] | r_pending[Chk_RA2];
    assign w_fifo_wdata = {Req_Op, Req_Op1, Req_Op2, Req_WA3};
    assign w_head       = w_fifo_rdata[ENT_W-1 -: PAY_W];
    assign w_head_wa3   = w_fifo_rdata[REG_AW-1:0];
    assign w_pop        = (r_state == ST_ISSUE);
    assign w_retire     = (r_state == ST_WB) & WB_Ready;
    assign Idle         = (w_count == '0) & (r_state == ST_IDLE);
    assign Dbg_State    = r_state;

    fpu_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .CLK     (CLK),
        .Reset   (Reset),
        .i_push  (w_accept),
        .i_pop   (w_pop),
        .i_data  (w_fifo_wdata),
        .o_data  (w_fifo_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        w_next       = r_state;
        FPU_Start    = 1'b0;
        FPU_Op       = FPU_OP_ADD;
        FPU_Operand1 = '0;
        FPU_Operand2 = '0;
        WB_Valid     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty && !FPU_Busy) w_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                FPU_Start    = 1'b1;
                FPU_Op       = w_head.op;
                FPU_Operand1 = w_head.op1;
                FPU_Operand2 = w_head.op2;
                w_next       = ST_WAIT;
            end
            ST_WAIT: begin
                if (FPU_Done)       w_next = ST_WB;
                else if (w_timeout) w_next = ST_IDLE;
            end
            ST_WB: begin
                WB_Valid = 1'b1;
                // Chain straight into the next issue to avoid an IDLE bubble.
                if (WB_Ready) w_next = (!w_empty && !FPU_Busy) ? ST_ISSUE : ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
            r_cur_wa3 <= '0;
            WB_WA3    <= '0;
            WB_Result <= '0;
        end else begin
            r_state <= w_next;
            // Set and clear never target the same bit: a set requires the bit
            // to be clear, a clear targets a bit that is set.
            if (w_accept)  r_pending[Req_WA3]   <= 1'b1;
            if (w_retire)  r_pending[WB_WA3]    <= 1'b0;
            if (w_timeout) r_pending[r_cur_wa3] <= 1'b0;
            if (r_state == ST_ISSUE) r_cur_wa3 <= w_head_wa3;
            if (r_state == ST_WAIT && FPU_Done) begin
                WB_Result <= FPU_Result;
                WB_WA3    <= r_cur_wa3;
            end
        end
    end

`ifdef FPU_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_timer;
    logic          r_error;

    // r_timer equals the number of WAIT cycles already elapsed, so the
    // watchdog fires in the TIMEOUT_CYCLES-th WAIT cycle without a Done.
    assign w_timeout = (r_state == ST_WAIT) & ~FPU_Done &
                       (r_timer == TW'(TIMEOUT_CYCLES - 1));
    assign Error     = r_error;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_timer <= '0;
            r_error <= 1'b0;
        end else begin
            if (r_state == ST_ISSUE)     r_timer <= '0;
            else if (r_state == ST_WAIT) r_timer <= r_timer + 1'b1;
            if (w_timeout) r_error <= 1'b1;
        end
    end
`else
    logic w_unused_timeout_cfg;

    assign w_timeout            = 1'b0;
    assign Error                = 1'b0;
    assign w_unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
module tb_fpu_issue_ctrl;
    import fpu_ctrl_pkg::*;

    localparam int unsigned AW = 4;

    logic          CLK = 1'b0;
    logic          Reset;
    logic          Req_Valid;
    logic          Req_Ready;
    logic          Req_Op;
    logic [31:0]   Req_Op1;
    logic [31:0]   Req_Op2;
    logic [AW-1:0] Req_WA3;
    logic [AW-1:0] Chk_RA1;
    logic [AW-1:0] Chk_RA2;
    logic          Chk_Hazard;
    logic          FPU_Start;
    logic          FPU_Op;
    logic [31:0]   FPU_Operand1;
    logic [31:0]   FPU_Operand2;
    logic          FPU_Busy;
    logic          FPU_Done;
    logic [31:0]   FPU_Result;
    logic          WB_Valid;
    logic [AW-1:0] WB_WA3;
    logic [31:0]   WB_Result;
    logic          WB_Ready;
    logic          Idle;
    logic          Error;
    logic [1:0]    Dbg_State;

    // FPU model controls
    logic busy_force;
    logic fpu_active;
    logic drop_op;
    int   fpu_delay;

    // Scoreboard queues
    logic [AW+31:0] exp_q[$];   // {wa3, result} in retire order
    logic [64:0]    iss_q[$];   // {op, op1, op2} in issue order
    logic [31:0]    res_q[$];   // result the FPU model returns per issue

    int n_checks = 0;
    int n_errors = 0;
    int start_cnt = 0;
    int op_zero_bad = 0;

    assign FPU_Busy = busy_force | fpu_active;

    always #5 CLK = ~CLK;

    fpu_issue_ctrl #(.DEPTH(4), .REG_AW(AW), .TIMEOUT_CYCLES(64)) dut (
        .CLK(CLK), .Reset(Reset),
        .Req_Valid(Req_Valid), .Req_Ready(Req_Ready), .Req_Op(Req_Op),
        .Req_Op1(Req_Op1), .Req_Op2(Req_Op2), .Req_WA3(Req_WA3),
        .Chk_RA1(Chk_RA1), .Chk_RA2(Chk_RA2), .Chk_Hazard(Chk_Hazard),
        .FPU_Start(FPU_Start), .FPU_Op(FPU_Op),
        .FPU_Operand1(FPU_Operand1), .FPU_Operand2(FPU_Operand2),
        .FPU_Busy(FPU_Busy), .FPU_Done(FPU_Done), .FPU_Result(FPU_Result),
        .WB_Valid(WB_Valid), .WB_WA3(WB_WA3), .WB_Result(WB_Result),
        .WB_Ready(WB_Ready), .Idle(Idle), .Error(Error), .Dbg_State(Dbg_State)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive phase: 1 time unit after the active edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_exp(input logic op, input logic [31:0] a, input logic [31:0] b,
                            input logic [AW-1:0] wa3, input logic [31:0] res, input bit exp_wb);
        iss_q.push_back({op, a, b});
        res_q.push_back(res);
        if (exp_wb) exp_q.push_back({wa3, res});
    endtask

    // Called in the drive phase; returns in the drive phase after acceptance.
    task automatic send(input logic op, input logic [31:0] a, input logic [31:0] b,
                        input logic [AW-1:0] wa3, input logic [31:0] res, input bit exp_wb);
        bit ok = 0;
        Req_Valid = 1'b1; Req_Op = op; Req_Op1 = a; Req_Op2 = b; Req_WA3 = wa3;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (Req_Ready) begin ok = 1; break; end
            tick();
        end
        check("send_accept_in_budget", ok, 1);
        if (ok) push_exp(op, a, b, wa3, res, exp_wb);
        tick();
        Req_Valid = 1'b0;
    endtask

    task automatic drain(input string name);
        bit ok = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            @(negedge CLK);
            if (exp_q.size() == 0 && Idle) begin ok = 1; break; end
        end
        check(name, ok, 1);
    endtask

    // FPU model: checks each issue against the expected queue and returns the
    // bench-supplied result fpu_delay cycles after Start.
    initial begin
        FPU_Done = 1'b0; FPU_Result = '0; fpu_active = 1'b0;
        forever begin
            @(negedge CLK);
            if (FPU_Start === 1'b1) begin
                logic [31:0] r;
                bit          drop;
                start_cnt++;
                check("issue_expected", iss_q.size() != 0, 1);
                if (iss_q.size() != 0)
                    check("issue_op_operands", {FPU_Op, FPU_Operand1, FPU_Operand2}, iss_q.pop_front());
                r    = (res_q.size() != 0) ? res_q.pop_front() : 32'hDEAD_BEEF;
                drop = drop_op;
                tick();
                fpu_active = 1'b1;
                repeat (fpu_delay - 1) tick();
                if (!drop) begin FPU_Done = 1'b1; FPU_Result = r; end
                tick();
                FPU_Done = 1'b0; fpu_active = 1'b0;
            end else if (FPU_Op !== 1'b0 || FPU_Operand1 !== '0 || FPU_Operand2 !== '0) begin
                op_zero_bad++;
            end
        end
    end

    // Writeback monitor: every retire must match the oldest expected result.
    initial begin
        forever begin
            @(negedge CLK);
            if (WB_Valid === 1'b1 && WB_Ready === 1'b1) begin
                check("wb_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("wb_wa3_result", {WB_WA3, WB_Result}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  s0;
        int  cnt;
        bit  bad;
        bit  found;
        logic [31:0]   cap_r;
        logic [AW-1:0] cap_a;

        Reset = 1'b1; Req_Valid = 1'b0; Req_Op = 1'b0; Req_Op1 = '0; Req_Op2 = '0;
        Req_WA3 = '0; Chk_RA1 = '0; Chk_RA2 = '0; WB_Ready = 1'b1;
        busy_force = 1'b0; drop_op = 1'b0; fpu_delay = 4;
        tick(); tick();
        @(negedge CLK);
        check("rst_fpu_start", FPU_Start, 0);
        check("rst_wb_valid", WB_Valid, 0);
        check("rst_wb_wa3", WB_WA3, 0);
        check("rst_wb_result", WB_Result, 0);
        check("rst_error", Error, 0);
        check("rst_idle", Idle, 1);
        check("rst_req_ready", Req_Ready, 1);
        check("rst_hazard", Chk_Hazard, 0);
        check("rst_state", Dbg_State, ST_IDLE);
        tick();
        Reset = 1'b0;
        tick();

        // Single add: 1.0 + 2.0 = 3.0 into r5
        Chk_RA1 = 4'd5; Chk_RA2 = 4'd0;
        s0 = start_cnt;
        send(FPU_OP_ADD, 32'h3F80_0000, 32'h4000_0000, 4'd5, 32'h4040_0000, 1);
        @(negedge CLK);
        check("add_no_start_yet", FPU_Start, 0);
        check("add_hazard_set", Chk_Hazard, 1);
        tick();
        @(negedge CLK);
        check("add_start_latency", FPU_Start, 1);
        bad = 0; found = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            @(negedge CLK);
            if (!Chk_Hazard) bad = 1;
            if (WB_Valid) begin found = 1; break; end
        end
        check("add_wb_seen", found, 1);
        check("add_hazard_until_wb", bad, 0);
        tick();
        @(negedge CLK);
        check("add_wb_one_cycle", WB_Valid, 0);
        check("add_hazard_cleared", Chk_Hazard, 0);
        check("add_idle_after", Idle, 1);
        check("add_one_start", start_cnt - s0, 1);
        tick();

        // Fill: four muls with the FPU held busy
        busy_force = 1'b1;
        tick();
        s0 = start_cnt;
        send(FPU_OP_MUL, 32'h4000_0000, 32'h4040_0000, 4'd1, 32'h40C0_0000, 1);
        send(FPU_OP_MUL, 32'h4000_0000, 32'h4000_0000, 4'd2, 32'h4080_0000, 1);
        send(FPU_OP_MUL, 32'h3F80_0000, 32'h40A0_0000, 4'd3, 32'h40A0_0000, 1);
        send(FPU_OP_MUL, 32'h4040_0000, 32'h4040_0000, 4'd4, 32'h4110_0000, 1);
        Req_Op = FPU_OP_MUL; Req_Op1 = 32'h4000_0000; Req_Op2 = 32'h4080_0000; Req_WA3 = 4'd9;
        @(negedge CLK);
        check("fill_full_blocks", Req_Ready, 0);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge CLK);
            if (Req_Ready) bad = 1;
        end
        check("fill_stall_holds", bad, 0);
        check("fill_no_issue_while_busy", start_cnt - s0, 0);
        tick();
        busy_force = 1'b0;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (FPU_Start) begin
                check("fill_no_bypass", Req_Ready, 0);
                tick();
                @(negedge CLK);
                check("fill_reopen", Req_Ready, 1);
                found = 1;
                break;
            end
            tick();
        end
        check("fill_issue_seen", found, 1);
        Req_Valid = 1'b1;
        push_exp(FPU_OP_MUL, 32'h4000_0000, 32'h4080_0000, 4'd9, 32'h4100_0000, 1);
        tick();
        Req_Valid = 1'b0;
        drain("fill_drain");

        // WAW stall on r7
        fpu_delay = 6;
        tick();
        send(FPU_OP_ADD, 32'h4000_0000, 32'h4000_0000, 4'd7, 32'h4080_0000, 1);
        Req_Valid = 1'b1; Req_Op = FPU_OP_ADD; Req_Op1 = 32'h4080_0000;
        Req_Op2 = 32'h3F80_0000; Req_WA3 = 4'd7;
        cnt = 0; found = 0; bad = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (Req_Ready) begin bad = 0; break; end
            cnt++;
            if (WB_Valid && WB_Ready && WB_WA3 == 4'd7) found = 1;
            tick();
        end
        check("waw_accepted_in_budget", bad, 0);
        check("waw_ready_after_wb", found, 1);
        check("waw_stalled", cnt > 3, 1);
        if (!bad) push_exp(FPU_OP_ADD, 32'h4080_0000, 32'h3F80_0000, 4'd7, 32'h40A0_0000, 1);
        tick();
        Req_Valid = 1'b0;
        drain("waw_drain");

        // Write-port backpressure
        fpu_delay = 3;
        tick();
        WB_Ready = 1'b0;
        Chk_RA1 = 4'd10; Chk_RA2 = 4'd11;
        send(FPU_OP_ADD, 32'h40A0_0000, 32'h40A0_0000, 4'd10, 32'h4120_0000, 1);
        send(FPU_OP_MUL, 32'h4040_0000, 32'h4080_0000, 4'd11, 32'h4140_0000, 1);
        found = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            @(negedge CLK);
            if (WB_Valid) begin found = 1; break; end
        end
        check("bp_wb_seen", found, 1);
        cap_r = WB_Result; cap_a = WB_WA3; s0 = start_cnt; bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge CLK);
            if (!WB_Valid || WB_Result !== cap_r || WB_WA3 !== cap_a) bad = 1;
        end
        check("bp_stable", bad, 0);
        check("bp_no_start", start_cnt - s0, 0);
        check("bp_hazard", Chk_Hazard, 1);
        tick();
        WB_Ready = 1'b1;
        drain("bp_drain");

        // Reset in the middle of WAIT, with a second op still queued
        fpu_delay = 8;
        tick();
        s0 = start_cnt;
        Chk_RA1 = 4'd12; Chk_RA2 = 4'd13;
        send(FPU_OP_ADD, 32'h3F80_0000, 32'h3F80_0000, 4'd12, 32'h4000_0000, 0);
        send(FPU_OP_ADD, 32'h4000_0000, 32'h3F80_0000, 4'd13, 32'h4040_0000, 0);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (start_cnt != s0) begin found = 1; break; end
            tick();
        end
        check("rstw_issue_seen", found, 1);
        tick(); tick();
        check("rstw_in_wait", Dbg_State, ST_WAIT);
        Reset = 1'b1;
        Req_WA3 = 4'd12;
        #1;
        check("rstw_start", FPU_Start, 0);
        check("rstw_wb_valid", WB_Valid, 0);
        check("rstw_wb_wa3", WB_WA3, 0);
        check("rstw_wb_result", WB_Result, 0);
        check("rstw_idle", Idle, 1);
        check("rstw_hazard", Chk_Hazard, 0);
        check("rstw_req_ready", Req_Ready, 1);
        tick();
        Reset = 1'b0;
        iss_q.delete();
        res_q.delete();
        s0 = start_cnt; bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            @(negedge CLK);
            if (WB_Valid || FPU_Start) bad = 1;
        end
        check("rstw_late_done_ignored", bad, 0);
        check("rstw_fifo_emptied", start_cnt - s0, 0);
        check("rstw_idle_after", Idle, 1);
        fpu_delay = 2;
        tick();
        send(FPU_OP_ADD, 32'h3F80_0000, 32'h3F80_0000, 4'd12, 32'h4000_0000, 1);
        drain("rstw_recover_drain");

`ifdef FPU_TIMEOUT_EN
        // Watchdog: first op never completes, second must still issue
        drop_op = 1'b1;
        Chk_RA1 = 4'd14; Chk_RA2 = 4'd14;
        tick();
        send(FPU_OP_ADD, 32'h3F80_0000, 32'h3F80_0000, 4'd14, 32'h0, 0);
        tick();
        drop_op = 1'b0;
        send(FPU_OP_MUL, 32'h4000_0000, 32'h4000_0000, 4'd15, 32'h4080_0000, 1);
        found = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            @(negedge CLK);
            if (Error) begin found = 1; break; end
        end
        check("to_error_set", found, 1);
        check("to_pending_cleared", Chk_Hazard, 0);
        drain("to_drain");
        check("to_error_sticky", Error, 1);
`endif

        check("final_wb_queue_empty", exp_q.size(), 0);
        check("final_issue_queue_empty", iss_q.size(), 0);
        check("operands_zero_outside_issue", op_zero_bad, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
